id_stage_reg: RTL and testbench
===============================

ID_STAGE_REG -- requirements
Module: id_stage_reg

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset; ports are listed clock and reset first.
REQ-002 The module SHALL expose: clk  in  1  rising-edge clock.
REQ-003 The module SHALL expose: rst  in  1  synchronous active-high reset.
REQ-004 The module SHALL expose: freeze  in  1  hazard stall; hold current contents.
REQ-005 The module SHALL expose: flush  in  1  taken-branch kill; load a bubble.
REQ-006 The module SHALL expose: valid_in  in  1  ID holds a real instruction.
REQ-007 The module SHALL expose: PC_in  in  32  instruction PC+4.
REQ-008 The module SHALL expose: Val_Rn_in, Val_Rm_in  in  32 each  register-file read data.
REQ-009 The module SHALL expose: src1_in, src2_in, Dest_in  in  4 each  source and destination register numbers.
REQ-010 The module SHALL expose: EXE_CMD_in  in  4  ALU opcode.
REQ-011 The module SHALL expose: MEM_R_EN_in, MEM_W_EN_in, WB_EN_in, B_in, S_in, imm_in  in  1 each  control bits.
REQ-012 The module SHALL expose: Shift_operand_in  in  12; Signed_imm_24_in  in  24; C_in  in  1  status carry.
REQ-013 The module SHALL expose a registered output of the same width for every data and control input above (suffix dropped), plus valid  out  1.
REQ-014 The module SHALL expose: bubble_cnt  out  16  saturating count of bubbles loaded (flush or freeze-induced).

Function
REQ-015 Update priority each rising edge SHALL be rst > flush > freeze > load.
REQ-016 Load (no rst/flush/freeze) SHALL capture all inputs; latency from input to output SHALL be exactly 1 cycle.
REQ-017 Flush SHALL clear WB_EN, MEM_R_EN, MEM_W_EN, B, S, valid to 0, set EXE_CMD to the NOP code, and clear all other fields to 0.
REQ-018 Freeze without flush SHALL hold every output, including valid, unchanged.
REQ-019 Flush with freeze asserted in the same cycle SHALL perform the flush.
REQ-020 valid_in=0 on a load SHALL be treated as a flush (bubble), so no control bit ever leaves with valid=0.
REQ-021 Invariant: valid=0 SHALL imply WB_EN=MEM_R_EN=MEM_W_EN=B=S=0 on every cycle.
REQ-022 src1, src2 SHALL be 0 while valid=0, so a downstream forwarding comparison matches only register 0 and only when a producer writes R0.
REQ-023 bubble_cnt SHALL increment by 1 on each edge where a bubble is loaded (flush, or load with valid_in=0) and SHALL saturate at 0xFFFF without wrapping.
REQ-024 bubble_cnt SHALL not change during freeze without flush.
REQ-025 All outputs SHALL be driven directly from flops; no combinational input-to-output path.

Reset
REQ-026 While rst=1 at a rising edge, all outputs SHALL load the bubble state of REQ-017 and bubble_cnt SHALL load 0.
REQ-027 Reset asserted mid-freeze or mid-flush SHALL override both; the first edge after rst deasserts SHALL follow REQ-015 normally.

Structure
REQ-028 EXE_CMD encodings, the NOP code (4'b0000), and register-number width (4) SHALL live in the shared pipeline package.
REQ-029 A single sub-module pipe_field_reg SHALL implement a width-parameterised register with load-enable and synchronous clear, instantiated per field group.
REQ-030 bubble_cnt logic SHALL reside in the top module, not in the sub-module.

Verification
REQ-031 Reset: rst=1 two cycles with random inputs -> all outputs 0, EXE_CMD=NOP, valid=0, bubble_cnt=0.
REQ-032 Load: PC_in=0x100, Dest_in=4'd5, WB_EN_in=1, valid_in=1 -> next cycle PC=0x100, Dest=5, WB_EN=1, valid=1.
REQ-033 Freeze: load Dest=5, then freeze=1 for 3 cycles while Dest_in=9 -> Dest stays 5, valid stays 1, bubble_cnt unchanged.
REQ-034 Flush+freeze same cycle with MEM_W_EN_in=1 -> next cycle MEM_W_EN=0, valid=0, src1=src2=0, bubble_cnt +1.
REQ-035 Saturation: preload bubble_cnt=0xFFFE via 65534 flushes, then 3 more flushes -> bubble_cnt=0xFFFF and holds.
REQ-036 Random stimulus with checker -> REQ-021 invariant holds every cycle over 10,000 cycles.

Source files
------------

// File: rtl/id_stage_reg_pkg.sv
// Shared pipeline definitions for the ID/EX boundary: register-number width,
// ALU opcode encodings and bubble-counter helpers.
package id_stage_reg_pkg;

   localparam int REG_W = 4;
   localparam int EXE_W = 4;
   localparam int CNT_W = 16;

   localparam logic [EXE_W-1:0] EXE_NOP = 4'b0000;
   localparam logic [EXE_W-1:0] EXE_MOV = 4'b0001;
   localparam logic [EXE_W-1:0] EXE_ADD = 4'b0010;
   localparam logic [EXE_W-1:0] EXE_ADC = 4'b0011;
   localparam logic [EXE_W-1:0] EXE_SUB = 4'b0100;
   localparam logic [EXE_W-1:0] EXE_SBC = 4'b0101;
   localparam logic [EXE_W-1:0] EXE_AND = 4'b0110;
   localparam logic [EXE_W-1:0] EXE_ORR = 4'b0111;
   localparam logic [EXE_W-1:0] EXE_EOR = 4'b1000;
   localparam logic [EXE_W-1:0] EXE_MVN = 4'b1001;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/id_stage_reg_pipe_field_reg.sv
// Width-parameterised pipeline register with load-enable and a synchronous
// clear to a programmable value; clear wins over enable.
module pipe_field_reg #(
   parameter int           W       = 1,
   parameter logic [W-1:0] CLR_VAL = '0
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // NOTE: sequential state uses non-blocking assignment so every flop samples
   // pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk) begin
      if (clr)
         q <= CLR_VAL;
      else if (en)
         q <= d;
   end

endmodule

// File: rtl/id_stage_reg.sv
// ID/EX pipeline register: loads decoded fields, holds on freeze, and turns
// flushes or invalid slots into a clean bubble whose count is kept saturating.
module id_stage_reg
   import id_stage_reg_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             freeze,
   input  logic             flush,
   input  logic             valid_in,
   input  logic [31:0]      PC_in,
   input  logic [31:0]      Val_Rn_in,
   input  logic [31:0]      Val_Rm_in,
   input  logic [REG_W-1:0] src1_in,
   input  logic [REG_W-1:0] src2_in,
   input  logic [REG_W-1:0] Dest_in,
   input  logic [EXE_W-1:0] EXE_CMD_in,
   input  logic             MEM_R_EN_in,
   input  logic             MEM_W_EN_in,
   input  logic             WB_EN_in,
   input  logic             B_in,
   input  logic             S_in,
   input  logic             imm_in,
   input  logic [11:0]      Shift_operand_in,
   input  logic [23:0]      Signed_imm_24_in,
   input  logic             C_in,
   output logic [31:0]      PC,
   output logic [31:0]      Val_Rn,
   output logic [31:0]      Val_Rm,
   output logic [REG_W-1:0] src1,
   output logic [REG_W-1:0] src2,
   output logic [REG_W-1:0] Dest,
   output logic [EXE_W-1:0] EXE_CMD,
   output logic             MEM_R_EN,
   output logic             MEM_W_EN,
   output logic             WB_EN,
   output logic             B,
   output logic             S,
   output logic             imm,
   output logic [11:0]      Shift_operand,
   output logic [23:0]      Signed_imm_24,
   output logic             C,
   output logic             valid,
   output logic [CNT_W-1:0] bubble_cnt
);

   localparam int DATA_W = 32 + 32 + 32 + 12 + 24 + 1 + 1;
   localparam int REGS_W = 3 * REG_W;
   localparam int CTRL_W = 6;

   logic bubble_load;
   logic clr;
   logic en;

   // An invalid slot is only squashed when it would actually be loaded; a
   // freeze keeps whatever is already in the register.
   assign bubble_load = flush | (~freeze & ~valid_in);
   assign clr         = rst | bubble_load;
   assign en          = ~freeze;

   pipe_field_reg #(.W(DATA_W)) u_data (
      .clk (clk),
      .clr (clr),
      .en  (en),
      .d   ({PC_in, Val_Rn_in, Val_Rm_in, Shift_operand_in, Signed_imm_24_in, imm_in, C_in}),
      .q   ({PC, Val_Rn, Val_Rm, Shift_operand, Signed_imm_24, imm, C})
   );

   // Source numbers are cleared with the bubble so forwarding can only match R0.
   pipe_field_reg #(.W(REGS_W)) u_regs (
      .clk (clk),
      .clr (clr),
      .en  (en),
      .d   ({src1_in, src2_in, Dest_in}),
      .q   ({src1, src2, Dest})
   );

   // valid is loaded as 1 here: every path that would carry valid_in=0 clears.
   pipe_field_reg #(.W(CTRL_W)) u_ctrl (
      .clk (clk),
      .clr (clr),
      .en  (en),
      .d   ({WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, B_in, S_in, 1'b1}),
      .q   ({WB_EN, MEM_R_EN, MEM_W_EN, B, S, valid})
   );

   pipe_field_reg #(.W(EXE_W), .CLR_VAL(EXE_NOP)) u_exe (
      .clk (clk),
      .clr (clr),
      .en  (en),
      .d   (EXE_CMD_in),
      .q   (EXE_CMD)
   );

   always_ff @(posedge clk) begin
      if (rst)
         bubble_cnt <= '0;
      else if (bubble_load)
         bubble_cnt <= sat_inc(bubble_cnt);
   end

endmodule

// File: tb/tb_id_stage_reg.sv
// Directed table of ID/EX register transactions plus hand sequences for
// counter saturation and a randomized bubble-invariant sweep.
module tb_id_stage_reg;
   import id_stage_reg_pkg::*;

   logic        clk = 1'b0;
   logic        rst, freeze, flush, valid_in;
   logic [31:0] PC_in, Val_Rn_in, Val_Rm_in;
   logic [3:0]  src1_in, src2_in, Dest_in, EXE_CMD_in;
   logic        MEM_R_EN_in, MEM_W_EN_in, WB_EN_in, B_in, S_in, imm_in, C_in;
   logic [11:0] Shift_operand_in;
   logic [23:0] Signed_imm_24_in;

   logic [31:0] PC, Val_Rn, Val_Rm;
   logic [3:0]  src1, src2, Dest, EXE_CMD;
   logic        MEM_R_EN, MEM_W_EN, WB_EN, B, S, imm, C, valid;
   logic [11:0] Shift_operand;
   logic [23:0] Signed_imm_24;
   logic [15:0] bubble_cnt;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   id_stage_reg dut (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .valid_in(valid_in),
      .PC_in(PC_in), .Val_Rn_in(Val_Rn_in), .Val_Rm_in(Val_Rm_in),
      .src1_in(src1_in), .src2_in(src2_in), .Dest_in(Dest_in), .EXE_CMD_in(EXE_CMD_in),
      .MEM_R_EN_in(MEM_R_EN_in), .MEM_W_EN_in(MEM_W_EN_in), .WB_EN_in(WB_EN_in),
      .B_in(B_in), .S_in(S_in), .imm_in(imm_in),
      .Shift_operand_in(Shift_operand_in), .Signed_imm_24_in(Signed_imm_24_in), .C_in(C_in),
      .PC(PC), .Val_Rn(Val_Rn), .Val_Rm(Val_Rm), .src1(src1), .src2(src2), .Dest(Dest),
      .EXE_CMD(EXE_CMD), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .WB_EN(WB_EN),
      .B(B), .S(S), .imm(imm), .Shift_operand(Shift_operand), .Signed_imm_24(Signed_imm_24),
      .C(C), .valid(valid), .bubble_cnt(bubble_cnt)
   );

   typedef enum logic [1:0] {E_BUBBLE, E_LOAD, E_HOLD} exp_kind_t;

   // Inputs of one edge plus the hand-chosen outcome and expected counter value.
   typedef struct {
      logic        rst, flush, freeze, vin;
      logic [31:0] pc;
      logic [3:0]  dest, s1, s2, exe;
      logic        wb, mr, mw;
      exp_kind_t   kind;
      logic [15:0] cnt;
   } vec_t;

   // Fully resolved expected register contents.
   typedef struct {
      logic        valid;
      logic [31:0] pc;
      logic [3:0]  dest, s1, s2, exe;
      logic        wb, mr, mw;
   } exp_t;

   vec_t vecs[17];

   function automatic vec_t mk(input logic r, input logic fl, input logic fz, input logic vi,
                               input logic [31:0] pc, input logic [3:0] dest, input logic [3:0] s1,
                               input logic [3:0] s2, input logic [3:0] exe, input logic wb,
                               input logic mr, input logic mw, input exp_kind_t k,
                               input logic [15:0] cnt);
      vec_t v;
      v.rst = r; v.flush = fl; v.freeze = fz; v.vin = vi;
      v.pc = pc; v.dest = dest; v.s1 = s1; v.s2 = s2; v.exe = exe;
      v.wb = wb; v.mr = mr; v.mw = mw; v.kind = k; v.cnt = cnt;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // The remaining fields are derived from PC so that held/loaded data is traceable.
   task automatic drive(input vec_t v);
      rst = v.rst; flush = v.flush; freeze = v.freeze; valid_in = v.vin;
      PC_in = v.pc; Val_Rn_in = ~v.pc; Val_Rm_in = v.pc + 32'h11;
      src1_in = v.s1; src2_in = v.s2; Dest_in = v.dest; EXE_CMD_in = v.exe;
      WB_EN_in = v.wb; MEM_R_EN_in = v.mr; MEM_W_EN_in = v.mw;
      Shift_operand_in = v.pc[11:0]; Signed_imm_24_in = v.pc[23:0];
      imm_in = v.pc[4]; C_in = v.pc[5]; B_in = v.pc[6]; S_in = v.pc[7];
   endtask

   task automatic check_regs(input string tag, input exp_t e);
      logic [31:0] p;
      p = e.valid ? e.pc : 32'h0;
      check({tag, ".valid"},    valid,    e.valid);
      check({tag, ".PC"},       PC,       p);
      check({tag, ".Val_Rn"},   Val_Rn,   e.valid ? ~p : 32'h0);
      check({tag, ".Val_Rm"},   Val_Rm,   e.valid ? p + 32'h11 : 32'h0);
      check({tag, ".Dest"},     Dest,     e.dest);
      check({tag, ".src1"},     src1,     e.s1);
      check({tag, ".src2"},     src2,     e.s2);
      check({tag, ".EXE_CMD"},  EXE_CMD,  e.exe);
      check({tag, ".WB_EN"},    WB_EN,    e.wb);
      check({tag, ".MEM_R_EN"}, MEM_R_EN, e.mr);
      check({tag, ".MEM_W_EN"}, MEM_W_EN, e.mw);
      check({tag, ".Shift"},    Shift_operand, {20'h0, p[11:0]});
      check({tag, ".Simm24"},   Signed_imm_24, {8'h0, p[23:0]});
      check({tag, ".imm"},      imm, p[4]);
      check({tag, ".C"},        C,   p[5]);
      check({tag, ".B"},        B,   p[6]);
      check({tag, ".S"},        S,   p[7]);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      exp_t cur;
      vec_t v;

      // rst flush frz vin  pc            dest  s1    s2    exe      wb mr mw  outcome   cnt
      vecs[0]  = mk(1, 0, 0, 1, 32'hDEADBEEF, 4'd7, 4'd3, 4'd4, EXE_ADD, 1, 1, 1, E_BUBBLE, 16'd0);
      vecs[1]  = mk(1, 1, 1, 0, 32'h12345678, 4'd9, 4'd1, 4'd2, EXE_SUB, 1, 0, 1, E_BUBBLE, 16'd0);
      vecs[2]  = mk(0, 0, 0, 1, 32'h00000100, 4'd5, 4'd1, 4'd2, EXE_ADD, 1, 0, 0, E_LOAD,   16'd0);
      vecs[3]  = mk(0, 0, 1, 1, 32'h00000200, 4'd9, 4'd6, 4'd7, EXE_ORR, 0, 1, 1, E_HOLD,   16'd0);
      vecs[4]  = mk(0, 0, 1, 1, 32'h00000200, 4'd9, 4'd6, 4'd7, EXE_ORR, 0, 1, 1, E_HOLD,   16'd0);
      vecs[5]  = mk(0, 0, 1, 1, 32'h00000200, 4'd9, 4'd6, 4'd7, EXE_ORR, 0, 1, 1, E_HOLD,   16'd0);
      vecs[6]  = mk(0, 1, 1, 1, 32'h00000300, 4'd2, 4'd8, 4'd9, EXE_AND, 0, 0, 1, E_BUBBLE, 16'd1);
      vecs[7]  = mk(0, 0, 0, 1, 32'h000004F0, 4'd3, 4'd4, 4'd5, EXE_ADD, 1, 1, 0, E_LOAD,   16'd1);
      vecs[8]  = mk(0, 0, 0, 0, 32'h00000500, 4'd6, 4'd7, 4'd8, EXE_MOV, 1, 0, 0, E_BUBBLE, 16'd2);
      vecs[9]  = mk(0, 0, 1, 1, 32'h00000600, 4'd1, 4'd2, 4'd3, EXE_EOR, 1, 0, 1, E_HOLD,   16'd2);
      vecs[10] = mk(0, 0, 1, 0, 32'h00000610, 4'd1, 4'd2, 4'd3, EXE_EOR, 1, 0, 1, E_HOLD,   16'd2);
      vecs[11] = mk(0, 0, 0, 1, 32'h00FF07A0, 4'hF, 4'hE, 4'hD, EXE_SUB, 0, 0, 1, E_LOAD,   16'd2);
      vecs[12] = mk(0, 1, 0, 1, 32'h00000800, 4'd4, 4'd4, 4'd4, EXE_MVN, 1, 1, 1, E_BUBBLE, 16'd3);
      vecs[13] = mk(1, 1, 0, 1, 32'h00000900, 4'd4, 4'd4, 4'd4, EXE_MVN, 1, 1, 1, E_BUBBLE, 16'd0);
      vecs[14] = mk(0, 0, 0, 1, 32'hA5A5A5C0, 4'd8, 4'd9, 4'hA, EXE_SBC, 1, 0, 0, E_LOAD,   16'd0);
      vecs[15] = mk(1, 0, 1, 1, 32'h00000A00, 4'd2, 4'd3, 4'd4, EXE_ADC, 1, 1, 0, E_BUBBLE, 16'd0);
      vecs[16] = mk(0, 0, 0, 1, 32'h00000B30, 4'hC, 4'd0, 4'hB, EXE_ADC, 0, 1, 0, E_LOAD,   16'd0);

      cur = '{valid: 1'b0, pc: 32'h0, dest: 4'h0, s1: 4'h0, s2: 4'h0, exe: EXE_NOP,
              wb: 1'b0, mr: 1'b0, mw: 1'b0};

      for (int i = 0; i < 17; i++) begin
         drive(vecs[i]);
         tick();
         case (vecs[i].kind)
            E_BUBBLE: cur = '{valid: 1'b0, pc: 32'h0, dest: 4'h0, s1: 4'h0, s2: 4'h0,
                              exe: EXE_NOP, wb: 1'b0, mr: 1'b0, mw: 1'b0};
            E_LOAD:   cur = '{valid: 1'b1, pc: vecs[i].pc, dest: vecs[i].dest, s1: vecs[i].s1,
                              s2: vecs[i].s2, exe: vecs[i].exe, wb: vecs[i].wb,
                              mr: vecs[i].mr, mw: vecs[i].mw};
            default:  ;
         endcase
         check_regs($sformatf("vec%0d", i), cur);
         check($sformatf("vec%0d.bubble_cnt", i), bubble_cnt, vecs[i].cnt);
      end

      // Saturation: from reset, 65534 flushes reach 0xFFFE, further flushes stick.
      v = mk(1, 0, 0, 1, 32'h0, 4'd0, 4'd0, 4'd0, EXE_NOP, 0, 0, 0, E_BUBBLE, 16'd0);
      drive(v);
      tick();
      check("sat.reset_cnt", bubble_cnt, 16'h0000);
      rst = 1'b0; flush = 1'b1;
      for (int i = 0; i < 65534; i++) @(posedge clk);
      #1;
      check("sat.preload", bubble_cnt, 16'hFFFE);
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("sat.flush%0d", i), bubble_cnt, 16'hFFFF);
      end
      flush = 1'b0; valid_in = 1'b0;
      tick();
      check("sat.invalid_load", bubble_cnt, 16'hFFFF);
      check("sat.valid", valid, 1'b0);

      // Random sweep: a non-valid slot must never carry control or source numbers.
      for (int i = 0; i < 10000; i++) begin
         rst      = ($urandom_range(63) == 0);
         flush    = ($urandom_range(7) == 0);
         freeze   = ($urandom_range(3) == 0);
         valid_in = ($urandom_range(3) != 0);
         PC_in = $urandom; Val_Rn_in = $urandom; Val_Rm_in = $urandom;
         src1_in = 4'($urandom); src2_in = 4'($urandom); Dest_in = 4'($urandom);
         EXE_CMD_in = 4'($urandom);
         {MEM_R_EN_in, MEM_W_EN_in, WB_EN_in, B_in, S_in, imm_in, C_in} = 7'($urandom);
         Shift_operand_in = 12'($urandom); Signed_imm_24_in = 24'($urandom);
         tick();
         if (valid === 1'b0)
            check($sformatf("rand%0d.bubble_ctrl", i),
                  {27'h0, WB_EN, MEM_R_EN, MEM_W_EN, B, S} | {24'h0, src1, src2}, 32'h0);
         else
            check($sformatf("rand%0d.valid_known", i), valid, 1'b1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
